// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the instruction loader
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = 2;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - little-endian byte-to-word shift register with byte index
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [7:0]        byte_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic [WORD_W-1:0] word_o
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  // Clear wins over load so a word boundary always starts from zero.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clr_i) begin
      word_d = '0;
      idx_d  = '0;
    end else if (load_i) begin
      word_d[8*idx_q +: 8] = byte_i;
      idx_d                = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign word_o = word_q;

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - byte-stream program loader writing packed words into instruction memory
module instr_loader
  import loader_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int               MAX_WORDS = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           byte_valid,
  input  logic [7:0]                     byte_data,
  input  logic                           byte_last,
  output logic                           byte_ready,
  output logic                           mem_we,
  output logic [WIDTH-1:0]               mem_addr,
  output logic [WIDTH-1:0]               mem_wd,
  output logic                           cpu_hold,
  output logic                           done,
  output logic                           error,
  output logic [$clog2(MAX_WORDS+1)-1:0] word_count
);

  localparam int               CW       = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0]    MAXW     = CW'(MAX_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      wc_q, wc_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic               last_q, last_d;
  logic               done_q, error_q, hold_q;
  logic               pk_clr, pk_load;
  logic [IDX_W-1:0]   pk_idx;
  logic [WORD_W-1:0]  pk_word;

  byte_packer u_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (pk_clr),
    .load_i (pk_load),
    .byte_i (byte_data),
    .idx_o  (pk_idx),
    .word_o (pk_word)
  );

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    addr_d  = addr_q;
    last_d  = last_q;
    pk_clr  = 1'b0;
    pk_load = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = RECV;
          wc_d    = '0;
          addr_d  = BASE_ADDR;
          last_d  = 1'b0;
          pk_clr  = 1'b1;
        end
      end
      RECV: begin
        if (byte_valid) begin
          pk_load = 1'b1;
          if (pk_idx == LAST_IDX || byte_last) begin
            last_d = byte_last;
            // A full memory diverts the word to ERR so no out-of-range write is issued.
            state_d = (wc_q == MAXW) ? ERR : WRITE;
          end
        end
      end
      WRITE: begin
        wc_d    = wc_q + 1'b1;
        addr_d  = addr_q + WIDTH'(BYTES_PER_WORD);
        pk_clr  = 1'b1;
        state_d = last_q ? DONE : RECV;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wc_q    <= '0;
      addr_q  <= BASE_ADDR;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      done_q  <= (state_d == DONE);
      error_q <= (state_d == ERR);
      hold_q  <= (state_d != DONE);
    end
  end

  assign byte_ready = (state_q == RECV);
  assign mem_we     = (state_q == WRITE);
  assign mem_addr   = addr_q;
  assign mem_wd     = pk_word;
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - randomized self-checking bench for instr_loader against a word-level model
module tb_instr_loader;

  typedef struct {
    int          d;
    logic [31:0] a;
    logic [31:0] w;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        st [2];
  logic        bv [2];
  logic [7:0]  bd [2];
  logic        bl [2];
  logic        br [2];
  logic        we [2];
  logic [31:0] addr [2];
  logic [31:0] wd [2];
  logic        hold [2];
  logic        dn [2];
  logic        er [2];
  logic [6:0]  wc0;
  logic [1:0]  wc1;

  int  n_pass = 0;
  int  n_total = 0;
  int  viol = 0;
  wr_t caps[$];

  always #5 clk = ~clk;

  instr_loader #(.WIDTH(32), .BASE_ADDR(32'h0000_0000), .MAX_WORDS(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .byte_valid(bv[0]), .byte_data(bd[0]),
    .byte_last(bl[0]), .byte_ready(br[0]), .mem_we(we[0]), .mem_addr(addr[0]),
    .mem_wd(wd[0]), .cpu_hold(hold[0]), .done(dn[0]), .error(er[0]), .word_count(wc0)
  );

  instr_loader #(.WIDTH(32), .BASE_ADDR(32'h0000_1000), .MAX_WORDS(2)) u_ovf (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .byte_valid(bv[1]), .byte_data(bd[1]),
    .byte_last(bl[1]), .byte_ready(br[1]), .mem_we(we[1]), .mem_addr(addr[1]),
    .mem_wd(wd[1]), .cpu_hold(hold[1]), .done(dn[1]), .error(er[1]), .word_count(wc1)
  );

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n && we[d]) caps.push_back('{d: d, a: addr[d], w: wd[d]});
      if (br[d] && we[d]) viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic int wc_of(input int d);
    return (d == 0) ? int'(wc0) : int'(wc1);
  endfunction

  task automatic pulse_start(input int d);
    @(negedge clk);
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
  endtask

  task automatic send(input int d, input logic [7:0] q[$], input int mode, input bit last_end);
    int i;
    int cyc;
    bit tog;
    bit v;
    i = 0; cyc = 0; tog = 1'b0;
    while (i < q.size() && cyc < 400 && !er[d]) begin
      @(negedge clk);
      cyc++;
      tog = !tog;
      v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      bv[d] = v;
      bd[d] = q[i];
      bl[d] = last_end && (i == q.size() - 1);
      if (v && br[d]) i++;
    end
    @(negedge clk);
    bv[d] = 1'b0;
    bl[d] = 1'b0;
    if (!er[d]) check("send_all_accepted", 32'(i), 32'(q.size()));
  endtask

  task automatic wait_end(input int d);
    for (int c = 0; c < 50 && !(dn[d] || er[d]); c++) @(negedge clk);
    check("load_finished", 32'(dn[d] || er[d]), 32'd1);
  endtask

  // Model: words = ceil(bytes/4), little-endian, zero-filled; overflow once words exceed capacity.
  task automatic check_load(input int d, input logic [7:0] q[$], input int s, input int v0);
    int          nbytes;
    int          words;
    int          maxw;
    int          nw;
    bit          ovf;
    logic [31:0] base;
    logic [31:0] exp_w;
    wr_t         got[$];
    nbytes = q.size();
    words  = (nbytes + 3) / 4;
    maxw   = (d == 0) ? 64 : 2;
    base   = (d == 0) ? 32'h0 : 32'h1000;
    ovf    = words > maxw;
    nw     = ovf ? maxw : words;
    for (int i = s; i < caps.size(); i++) if (caps[i].d == d) got.push_back(caps[i]);
    check("write_count", 32'(got.size()), 32'(nw));
    for (int w = 0; w < nw && w < got.size(); w++) begin
      exp_w = '0;
      for (int b = 0; b < 4; b++) if (4 * w + b < nbytes) exp_w[8*b +: 8] = q[4*w + b];
      check("mem_addr", got[w].a, base + 32'(4 * w));
      check("mem_wd", got[w].w, exp_w);
    end
    check("done", 32'(dn[d]), 32'(!ovf));
    check("error", 32'(er[d]), 32'(ovf));
    check("cpu_hold", 32'(hold[d]), 32'(ovf));
    check("word_count", 32'(wc_of(d)), 32'(nw));
    check("ready_in_write", 32'(viol - v0), 32'd0);
  endtask

  task automatic run_load(input int d, input logic [7:0] q[$], input int mode, input bit do_start);
    int s;
    int v0;
    s = caps.size();
    v0 = viol;
    if (do_start) pulse_start(d);
    send(d, q, mode, 1'b1);
    wait_end(d);
    check_load(d, q, s, v0);
  endtask

  task automatic check_reset_vals(input int d);
    check("rst_ready", 32'(br[d]), 32'd0);
    check("rst_we", 32'(we[d]), 32'd0);
    check("rst_addr", addr[d], (d == 0) ? 32'h0 : 32'h1000);
    check("rst_wd", wd[d], 32'h0);
    check("rst_done", 32'(dn[d]), 32'd0);
    check("rst_error", 32'(er[d]), 32'd0);
    check("rst_hold", 32'(hold[d]), 32'd1);
    check("rst_wc", 32'(wc_of(d)), 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] a[$];
    logic [7:0] b[$];
    int         s;
    int         v0;
    int         d;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; bv[i] = 1'b0; bd[i] = 8'h00; bl[i] = 1'b0;
    end
    #1 rst_n = 1'b0;
    #2;
    check_reset_vals(0);
    check_reset_vals(1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    run_load(0, q, 0, 1'b1);

    pulse_start(0);
    check("restart_done", 32'(dn[0]), 32'd0);
    check("restart_wc", 32'(wc_of(0)), 32'd0);
    check("restart_hold", 32'(hold[0]), 32'd1);
    check("restart_ready", 32'(br[0]), 32'd1);
    q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    run_load(0, q, 0, 1'b0);

    q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    run_load(0, q, 1, 1'b1);

    q = {};
    for (int i = 0; i < 12; i++) q.push_back(8'(8'h40 + i));
    run_load(1, q, 0, 1'b1);
    pulse_start(1);
    check("ovf_error_cleared", 32'(er[1]), 32'd0);
    check("ovf_hold_after_start", 32'(hold[1]), 32'd1);
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_load(1, q, 0, 1'b0);

    a = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    b = '{8'h01, 8'h23, 8'h45, 8'h67};
    s = caps.size();
    v0 = viol;
    pulse_start(0);
    send(0, a, 0, 1'b0);
    repeat (3) @(negedge clk);
    pulse_start(0);
    check("start_in_recv_wc", 32'(wc_of(0)), 32'd1);
    check("start_in_recv_ready", 32'(br[0]), 32'd1);
    send(0, b, 2, 1'b1);
    wait_end(0);
    check_load(0, {a, b}, s, v0);

    pulse_start(0);
    q = '{8'hC3, 8'h5A};
    send(0, q, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals(0);
    @(negedge clk);
    rst_n = 1'b1;
    q = '{8'h37, 8'h01, 8'h00, 8'h80};
    run_load(0, q, 0, 1'b1);

    for (int it = 0; it < 10; it++) begin
      d = it % 2;
      q = {};
      for (int i = 0, n = $urandom_range(1, (d == 0) ? 24 : 14); i < n; i++)
        q.push_back(8'($urandom_range(0, 255)));
      run_load(d, q, $urandom_range(0, 2), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
